// File: rtl/sfp_seq_pkg.sv
// Shared state encoding and sizing helpers for the SFP+ lane bring-up sequencer.
package sfp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_PLL  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_WAIT_LOCK = 3'd4,
    ST_UP        = 3'd5,
    ST_BACKOFF   = 3'd6,
    ST_FAULT     = 3'd7
  } state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Narrowest counter that can reach v and still hold one more without wrapping.
  function automatic int unsigned min_cnt_w(input int unsigned v);
    return $clog2(v) + 1;
  endfunction

endpackage

// File: rtl/sfp_los_sync.sv
// Two-flop synchroniser for asynchronous SFP status pins; resets to 1 so an
// unknown pin reads as "fault present" until it has been sampled twice.
module sfp_los_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/sfp_link_sequencer.sv
// Bring-up and recovery sequencer for one 10GBASE-R SFP+ PCS/PMA lane:
// reset -> PLL lock -> reset done -> debounced block lock, with timeouts and retries.
module sfp_link_sequencer
  import sfp_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned PLL_TIMEOUT    = 65536,
  parameter int unsigned DONE_TIMEOUT   = 65536,
  parameter int unsigned LOCK_TIMEOUT   = 1048576,
  parameter int unsigned LOCK_DEBOUNCE  = 64,
  parameter int unsigned BACKOFF_CYCLES = 4096,
  parameter int unsigned MAX_RETRIES    = 7,
  parameter int unsigned CNT_W          = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sfp_los,
  input  logic       qplllock,
  input  logic       resetdone,
  input  logic       rx_block_lock,
  input  logic       fault_clear,
  output logic       pcs_reset,
  output logic       link_up,
  output logic       fault,
  output logic [2:0] state_out,
  output logic [2:0] retry_cnt
);

  localparam int unsigned MAX_LIMIT =
    max2(max2(max2(RESET_CYCLES, PLL_TIMEOUT), max2(DONE_TIMEOUT, LOCK_TIMEOUT)),
         max2(LOCK_DEBOUNCE, BACKOFF_CYCLES));

  if (CNT_W < min_cnt_w(MAX_LIMIT)) begin : g_cnt_w_check
    $error("sfp_link_sequencer: CNT_W too narrow for the timing parameters");
  end

  localparam logic [CNT_W-1:0] L_RESET    = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] L_PLL      = CNT_W'(PLL_TIMEOUT);
  localparam logic [CNT_W-1:0] L_DONE     = CNT_W'(DONE_TIMEOUT);
  localparam logic [CNT_W-1:0] L_LOCK     = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] L_DEBOUNCE = CNT_W'(LOCK_DEBOUNCE);
  localparam logic [CNT_W-1:0] L_BACKOFF  = CNT_W'(BACKOFF_CYCLES);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_dbnc;
  logic [CNT_W-1:0] w_limit;
  logic [2:0]       r_retry;
  logic [2:0]       w_retry_next;
  logic [2:0]       w_retry_inc;
  logic             r_pcs_reset;
  logic             r_link_up;
  logic             r_fault;
  logic             w_los_sync;
  logic             w_expired;
  logic             w_dbnc_hit;
  logic             w_dbnc_in;
  logic             w_fail;
  logic             w_pcs_reset_nxt;

  sfp_los_sync #(
    .WIDTH (1)
  ) u_los_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (sfp_los),
    .o_sync  (w_los_sync)
  );

  // The single state timer counts cycles spent in the current state; expiry
  // fires on the cycle that completes the limit, so a state lasts exactly w_limit cycles.
  always_comb begin
    w_limit = '0;
    case (r_state)
      ST_RESET:     w_limit = L_RESET;
      ST_WAIT_PLL:  w_limit = L_PLL;
      ST_WAIT_DONE: w_limit = L_DONE;
      ST_WAIT_LOCK: w_limit = L_LOCK;
      ST_BACKOFF:   w_limit = L_BACKOFF;
      default:      w_limit = '0;
    endcase
  end

  assign w_expired   = (r_timer + CNT_W'(1)) >= w_limit;
  assign w_dbnc_hit  = r_dbnc >= L_DEBOUNCE;
  assign w_dbnc_in   = (r_state == ST_UP) ? !rx_block_lock : rx_block_lock;
  assign w_retry_inc = (r_retry == 3'd7) ? 3'd7 : r_retry + 3'd1;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry;
    w_fail       = 1'b0;

    case (r_state)
      ST_IDLE:      if (enable && !w_los_sync) w_next = ST_RESET;
      ST_RESET:     if (w_expired) w_next = ST_WAIT_PLL;
      ST_WAIT_PLL: begin
        if (qplllock)       w_next = ST_WAIT_DONE;
        else if (w_expired) w_fail = 1'b1;
      end
      ST_WAIT_DONE: begin
        if (resetdone)                   w_next = ST_WAIT_DONE == ST_WAIT_DONE ? ST_WAIT_LOCK : ST_WAIT_LOCK;
        else if (w_expired || !qplllock) w_fail = 1'b1;
      end
      ST_WAIT_LOCK: begin
        if (w_dbnc_hit) begin
          w_next       = ST_UP;
          w_retry_next = '0;
        end else if (w_expired || !qplllock || !resetdone) begin
          w_fail = 1'b1;
        end
      end
      ST_UP: begin
        if (!qplllock || !resetdone) w_next = ST_RESET;
        else if (w_dbnc_hit)         w_next = ST_WAIT_LOCK;
      end
      ST_BACKOFF:   if (w_expired) w_next = ST_RESET;
      ST_FAULT: begin
        if (fault_clear) begin
          w_next       = ST_IDLE;
          w_retry_next = '0;
        end
      end
      default:      w_next = ST_IDLE;
    endcase

    if (w_fail) begin
      w_retry_next = w_retry_inc;
      w_next       = (32'(w_retry_inc) >= MAX_RETRIES) ? ST_FAULT : ST_BACKOFF;
    end

    // Loss of enable or signal aborts the attempt without spending a retry.
    if ((r_state != ST_FAULT) && (!enable || w_los_sync)) begin
      w_next       = ST_IDLE;
      w_retry_next = r_retry;
    end
  end

  assign w_pcs_reset_nxt =
    !(w_next inside {ST_WAIT_PLL, ST_WAIT_DONE, ST_WAIT_LOCK, ST_UP});

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_dbnc      <= '0;
      r_retry     <= '0;
      r_pcs_reset <= 1'b1;
      r_link_up   <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_retry     <= w_retry_next;
      r_pcs_reset <= w_pcs_reset_nxt;
      r_link_up   <= (w_next == ST_UP);
      r_fault     <= (w_next == ST_FAULT);
      if (w_next != r_state) begin
        r_timer <= '0;
        r_dbnc  <= '0;
      end else begin
        if (r_timer < w_limit) r_timer <= r_timer + CNT_W'(1);
        if (!w_dbnc_in)                r_dbnc <= '0;
        else if (r_dbnc < L_DEBOUNCE)  r_dbnc <= r_dbnc + CNT_W'(1);
      end
    end
  end

  assign pcs_reset = r_pcs_reset;
  assign link_up   = r_link_up;
  assign fault     = r_fault;
  assign state_out = r_state;
  assign retry_cnt = r_retry;

endmodule

// File: tb/tb_sfp_link_sequencer.sv
// Directed bench for sfp_link_sequencer: bring-up, debounce, LOS abort,
// success/timeout tie, mid-run reset, and PLL-timeout retries into FAULT.
module tb_sfp_link_sequencer;
  import sfp_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       sfp_los;
  logic       qplllock;
  logic       resetdone;
  logic       rx_block_lock;
  logic       fault_clear;
  logic       pcs_reset;
  logic       link_up;
  logic       fault;
  logic [2:0] state_out;
  logic [2:0] retry_cnt;

  int total = 0;
  int bad   = 0;

  sfp_link_sequencer #(
    .RESET_CYCLES   (4),
    .PLL_TIMEOUT    (20),
    .DONE_TIMEOUT   (20),
    .LOCK_TIMEOUT   (40),
    .LOCK_DEBOUNCE  (8),
    .BACKOFF_CYCLES (10),
    .MAX_RETRIES    (3),
    .CNT_W          (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .sfp_los       (sfp_los),
    .qplllock      (qplllock),
    .resetdone     (resetdone),
    .rx_block_lock (rx_block_lock),
    .fault_clear   (fault_clear),
    .pcs_reset     (pcs_reset),
    .link_up       (link_up),
    .fault         (fault),
    .state_out     (state_out),
    .retry_cnt     (retry_cnt)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; inputs change and outputs are sampled 1 time unit later.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int n = 0;
    do begin
      cyc(1);
      n++;
    end while ((state_out !== target) && (n < budget));
    check(tag, 32'(state_out), 32'(target));
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; sfp_los = 1'b0; qplllock = 1'b0;
    resetdone = 1'b0; rx_block_lock = 1'b0; fault_clear = 1'b0;
    cyc(3);
    check("rst_state",     32'(state_out), 32'(ST_IDLE));
    check("rst_pcs_reset", 32'(pcs_reset), 1);
    check("rst_link_up",   32'(link_up),   0);
    check("rst_fault",     32'(fault),     0);
    check("rst_retry",     32'(retry_cnt), 0);

    // Nominal bring-up. LOS flops reset to 1, so IDLE lasts until they flush.
    rst_n = 1'b1;
    cyc(2); check("los_flush_idle",  32'(state_out), 32'(ST_IDLE));
    cyc(4); check("reset_hold_pcs",  32'(pcs_reset), 1);
            check("reset_hold_st",   32'(state_out), 32'(ST_RESET));
    cyc(1); check("reset_release",   32'(pcs_reset), 0);
            check("enter_wait_pll",  32'(state_out), 32'(ST_WAIT_PLL));
    cyc(10); qplllock = 1'b1;
    cyc(1); check("enter_wait_done", 32'(state_out), 32'(ST_WAIT_DONE));
    cyc(5); resetdone = 1'b1;
    cyc(1); check("enter_wait_lock", 32'(state_out), 32'(ST_WAIT_LOCK));
    cyc(3); rx_block_lock = 1'b1;
    cyc(8); check("up_not_yet",      32'(link_up),   0);
    cyc(1); check("up_link",         32'(link_up),   1);
            check("up_state",        32'(state_out), 32'(ST_UP));
            check("up_retry",        32'(retry_cnt), 0);

    // Lock glitches in UP: 7 cycles is tolerated, 8 drops back to WAIT_LOCK.
    rx_block_lock = 1'b0;
    cyc(7); rx_block_lock = 1'b1;
            check("glitch7_link",    32'(link_up),   1);
    cyc(2); check("glitch7_after",   32'(link_up),   1);
    rx_block_lock = 1'b0;
    cyc(8); rx_block_lock = 1'b1;
            check("glitch8_still_up", 32'(state_out), 32'(ST_UP));
    cyc(1); check("glitch8_state",   32'(state_out), 32'(ST_WAIT_LOCK));
            check("glitch8_pcs",     32'(pcs_reset), 0);
            check("glitch8_link",    32'(link_up),   0);
            check("glitch8_retry",   32'(retry_cnt), 0);

    // PLL drop in WAIT_LOCK is a failure: retry 1, then BACKOFF for 10 cycles.
    qplllock = 1'b0; rx_block_lock = 1'b0;
    cyc(1); check("pll_drop_state",  32'(state_out), 32'(ST_BACKOFF));
            check("pll_drop_retry",  32'(retry_cnt), 1);
            check("pll_drop_pcs",    32'(pcs_reset), 1);
    qplllock = 1'b1;
    cyc(9); check("backoff_last",    32'(state_out), 32'(ST_BACKOFF));
    cyc(1); check("backoff_done",    32'(state_out), 32'(ST_RESET));
    wait_state(ST_WAIT_LOCK, 20, "relock_wait");

    // LOS in WAIT_LOCK: IDLE three edges later, retry count untouched.
    sfp_los = 1'b1;
    cyc(2); check("los_sync_delay",  32'(state_out), 32'(ST_WAIT_LOCK));
    cyc(1); check("los_idle",        32'(state_out), 32'(ST_IDLE));
            check("los_retry",       32'(retry_cnt), 1);
            check("los_pcs",         32'(pcs_reset), 1);
    sfp_los = 1'b0;
    cyc(2); check("los_clear_delay", 32'(state_out), 32'(ST_IDLE));
    cyc(1); check("los_restart",     32'(state_out), 32'(ST_RESET));

    // Debounce completes on the same edge the lock timeout expires: success wins.
    wait_state(ST_WAIT_LOCK, 20, "tie_wait_lock");
    cyc(31); rx_block_lock = 1'b1;
    cyc(8); check("tie_before",      32'(state_out), 32'(ST_WAIT_LOCK));
    cyc(1); check("tie_state",       32'(state_out), 32'(ST_UP));
            check("tie_retry",       32'(retry_cnt), 0);
            check("tie_link",        32'(link_up),   1);

    // One-cycle reset while UP.
    rst_n = 1'b0;
    cyc(1); check("midrst_link",     32'(link_up),   0);
            check("midrst_pcs",      32'(pcs_reset), 1);
            check("midrst_state",    32'(state_out), 32'(ST_IDLE));
            check("midrst_retry",    32'(retry_cnt), 0);
    qplllock = 1'b0; resetdone = 1'b0; rx_block_lock = 1'b0;
    rst_n = 1'b1;

    // PLL never locks: three timeouts exhaust MAX_RETRIES=3.
    wait_state(ST_WAIT_PLL, 20, "pll1_wait");
    cyc(19); check("pll1_last",      32'(state_out), 32'(ST_WAIT_PLL));
    cyc(1);  check("pll1_fail",      32'(state_out), 32'(ST_BACKOFF));
             check("pll1_retry",     32'(retry_cnt), 1);
    wait_state(ST_WAIT_PLL, 30, "pll2_wait");
    cyc(20); check("pll2_fail",      32'(state_out), 32'(ST_BACKOFF));
             check("pll2_retry",     32'(retry_cnt), 2);
    fault_clear = 1'b1;
    cyc(1); fault_clear = 1'b0;
            check("clear_ignored_st",    32'(state_out), 32'(ST_BACKOFF));
            check("clear_ignored_retry", 32'(retry_cnt), 2);
    wait_state(ST_WAIT_PLL, 30, "pll3_wait");
    cyc(20); check("fault_state",    32'(state_out), 32'(ST_FAULT));
             check("fault_retry",    32'(retry_cnt), 3);
             check("fault_flag",     32'(fault),     1);
             check("fault_pcs",      32'(pcs_reset), 1);
    enable = 1'b0;
    cyc(2); check("fault_no_override", 32'(state_out), 32'(ST_FAULT));
    enable = 1'b1;
    fault_clear = 1'b1;
    cyc(1); fault_clear = 1'b0;
            check("clear_state",     32'(state_out), 32'(ST_IDLE));
            check("clear_retry",     32'(retry_cnt), 0);
            check("clear_fault",     32'(fault),     0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
